// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the radix-2 Booth multiplier datapath.
//   BOOTH_WIDTH  - default operand width in bits
//   booth_op_e   - Booth recoding action for one iteration
//   booth_decode - maps the recoding pair {Q[0], Q_m1} to an action
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // {Q[0], Q_m1}: 01 ends a run of ones (add M), 10 starts one (subtract M).
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration, purely combinational.
//   a, q, q_m1                   - current accumulator / multiplier / guard bit
//   m                            - sign-extended multiplicand (WIDTH+1 bits)
//   a_next, q_next, q_m1_next    - {A,Q,Q_m1} after add/sub and arithmetic shift
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  booth_op_e       op;
  logic [WIDTH:0]  sum;

  always_comb begin
    op  = booth_decode(q[0], q_m1);
    sum = a;
    case (op)
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    // Arithmetic right shift of {sum, q, q_m1}: the sign bit of A is replicated.
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_datapath.sv
// booth_datapath: radix-2 Booth signed-multiplier datapath, responder to the
// Booth controller FSM. Holds operands, accumulator and iteration counter and
// registers the final 2*WIDTH-bit product.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   multiplicand - signed operand M, sampled on en_i
//   multiplier   - signed operand Q, sampled on en_i
//   en_i         - load operands and start (highest priority, restarts if busy)
//   en_pp        - perform one Booth iteration
//   en_fp        - capture final product
//   valid_out    - all iterations complete (busy && count==0), from registers
//   product      - signed product, registered, held until the next capture
//   done         - one-cycle pulse in the cycle after the product updates
//
// Optional build macro: BOOTH_EARLY_TERM_EN. When defined, an accepted en_pp
// whose remaining multiplier bits Q[count-1:0] and Q_m1 are uniform finishes
// all remaining (no-op) iterations in one barrel shift and clears count.
//
// Handshake: the controller holds en_pp high while valid_out is low; once
// valid_out is high it asserts en_fp, which is accepted only while busy.
// Strobes that arrive when the datapath cannot use them are ignored.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 en_i,
  input  logic                 en_pp,
  input  logic                 en_fp,
  output logic                 valid_out,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  logic [WIDTH:0]   a_r;
  logic [WIDTH:0]   m_r;
  logic [WIDTH-1:0] q_r;
  logic             q_m1_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;

  logic [WIDTH:0]   step_a;
  logic [WIDTH-1:0] step_q;
  logic             step_q_m1;

  logic             early_term;
  logic             pp_accept;
  logic             fp_accept;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_r),
    .q         (q_r),
    .q_m1      (q_m1_r),
    .m         (m_r),
    .a_next    (step_a),
    .q_next    (step_q),
    .q_m1_next (step_q_m1)
  );

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0]          et_mask;
  logic [WIDTH-1:0]          et_bits;
  logic signed [2*WIDTH+1:0] et_vec;
  logic signed [2*WIDTH+1:0] et_shifted;

  always_comb begin
    // Low count bits set; a shift by WIDTH leaves the whole word selected.
    et_mask    = ~({WIDTH{1'b1}} << count_r);
    et_bits    = q_r & et_mask;
    // Uniform remaining bits mean every remaining step is a NOP plus shift.
    early_term = ((et_bits == '0) && !q_m1_r) ||
                 ((et_bits == et_mask) && q_m1_r);
    et_vec     = $signed({a_r, q_r, q_m1_r});
    et_shifted = et_vec >>> count_r;
  end
`else
  assign early_term = 1'b0;
`endif

  assign valid_out = busy_r && (count_r == '0);
  assign pp_accept = en_pp && busy_r && (count_r != '0);
  // With both strobes high, en_fp only wins once the iterations are finished.
  assign fp_accept = en_fp && busy_r && (valid_out || !en_pp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r     <= '0;
      m_r     <= '0;
      q_r     <= '0;
      q_m1_r  <= 1'b0;
      count_r <= '0;
      busy_r  <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en_i) begin
        a_r     <= '0;
        m_r     <= {multiplicand[WIDTH-1], multiplicand};
        q_r     <= multiplier;
        q_m1_r  <= 1'b0;
        count_r <= COUNT_INIT;
        busy_r  <= 1'b1;
      end else if (fp_accept) begin
        // A[WIDTH] is only a guard bit; the low 2*WIDTH bits are exact.
        product <= {a_r[WIDTH-1:0], q_r};
        busy_r  <= 1'b0;
        done    <= 1'b1;
      end else if (pp_accept) begin
`ifdef BOOTH_EARLY_TERM_EN
        if (early_term) begin
          {a_r, q_r, q_m1_r} <= et_shifted;
          count_r            <= '0;
        end else begin
          a_r     <= step_a;
          q_r     <= step_q;
          q_m1_r  <= step_q_m1;
          count_r <= count_r - 1'b1;
        end
`else
        a_r     <= step_a;
        q_r     <= step_q;
        q_m1_r  <= step_q_m1;
        count_r <= count_r - 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath: directed bench for booth_datapath (WIDTH=8). A small
// controller model in run_op drives en_i / en_pp / en_fp the way the Booth
// controller does; the stray-enable scenario drives the strobes directly.
module tb_booth_datapath;

  localparam int WIDTH = 8;

`ifdef BOOTH_EARLY_TERM_EN
  localparam int PP_7X3 = 4;
  localparam int PP_1X1 = 3;
`else
  localparam int PP_7X3 = 8;
  localparam int PP_1X1 = 8;
`endif

  logic                 clk;
  logic                 reset;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 en_i;
  logic                 en_pp;
  logic                 en_fp;
  logic                 valid_out;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  logic [2*WIDTH-1:0] exp_q[$];

  booth_datapath #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .en_i         (en_i),
    .en_pp        (en_pp),
    .en_fp        (en_fp),
    .valid_out    (valid_out),
    .product      (product),
    .done         (done)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Controller model: load, en_pp until valid_out, then en_fp. Inputs change
  // and outputs are sampled on the falling edge. lat counts cycles from the
  // en_i cycle to the cycle where done is seen; dn counts done-high cycles
  // through two cycles past the first one.
  task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                        output int pp_n, output int lat, output int dn,
                        output logic [2*WIDTH-1:0] prod);
    bit fp_sent;
    fp_sent = 1'b0;
    pp_n = 0;
    lat  = -1;
    dn   = 0;
    prod = 'x;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    en_i  = 1'b1;
    en_pp = 1'b0;
    en_fp = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      en_i  = 1'b0;
      en_pp = 1'b0;
      en_fp = 1'b0;
      if (done) begin
        dn++;
        if (lat < 0) begin
          lat  = c;
          prod = product;
        end
      end
      if (lat >= 0 && c >= lat + 2) break;
      if (!fp_sent) begin
        if (valid_out) begin
          en_fp   = 1'b1;
          fp_sent = 1'b1;
        end else begin
          en_pp = 1'b1;
          pp_n++;
        end
      end
    end
    en_i  = 1'b0;
    en_pp = 1'b0;
    en_fp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    en_i  = 1'b0;
    en_pp = 1'b0;
    en_fp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_product: got %h expected 0000", product);
    end
    checks++;
    if (done !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got done=%b valid_out=%b expected 0 0", done, valid_out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int pp, lat, dn;
    logic [2*WIDTH-1:0] prod, exp;
    exp_q.push_back(16'h0015);
    run_op(8'h07, 8'h03, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp) begin
      failures++;
      $display("FAIL basic_7x3: got %h expected %h", prod, exp);
    end
    checks++;
    if (pp !== PP_7X3) begin
      failures++;
      $display("FAIL basic_pp_count: got %0d expected %0d", pp, PP_7X3);
    end
    checks++;
    if (lat !== PP_7X3 + 2) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, PP_7X3 + 2);
    end
    checks++;
    if (dn !== 1) begin
      failures++;
      $display("FAIL basic_done_pulses: got %0d expected 1", dn);
    end
  endtask

  task automatic test_back_to_back();
    int pp, lat, dn;
    logic [2*WIDTH-1:0] prod, exp;
    exp_q.push_back(16'hFFE2);
    exp_q.push_back(16'h4000);
    run_op(8'hFB, 8'h06, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp || dn !== 1) begin
      failures++;
      $display("FAIL b2b_m5x6: got %h done=%0d expected %h done=1", prod, dn, exp);
    end
    run_op(8'h80, 8'h80, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp || dn !== 1) begin
      failures++;
      $display("FAIL b2b_m128xm128: got %h done=%0d expected %h done=1", prod, dn, exp);
    end
  endtask

  task automatic test_edge_operands();
    int pp, lat, dn;
    logic [2*WIDTH-1:0] prod, exp;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hC080);
    run_op(8'h00, 8'hFF, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp || dn !== 1) begin
      failures++;
      $display("FAIL edge_0xm1: got %h done=%0d expected %h done=1", prod, dn, exp);
    end
    run_op(8'h7F, 8'h80, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp || dn !== 1) begin
      failures++;
      $display("FAIL edge_127xm128: got %h done=%0d expected %h done=1", prod, dn, exp);
    end
  endtask

  task automatic test_stray_enables();
    int n;
    // 12 x 85 loaded directly; Q=0x55 never lets early termination kick in.
    @(negedge clk);
    multiplicand = 8'h0C;
    multiplier   = 8'h55;
    en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en_i  = 1'b0;
      en_pp = 1'b1;
    end
    @(negedge clk);
    en_pp = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL stray_valid_after_8: got %b expected 1", valid_out);
    end
    // Stray en_pp with count==0 must leave the state alone.
    en_pp = 1'b1;
    @(negedge clk);
    en_pp = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL stray_pp: got valid_out=%b done=%b expected 1 0", valid_out, done);
    end
    en_fp = 1'b1;
    @(negedge clk);
    en_fp = 1'b0;
    checks++;
    if (product !== 16'h03FC || done !== 1'b1) begin
      failures++;
      $display("FAIL stray_capture: got %h done=%b expected 03fc done=1", product, done);
    end
    // en_fp while idle: no capture, no done.
    en_fp = 1'b1;
    @(negedge clk);
    en_fp = 1'b0;
    @(negedge clk);
    checks++;
    if (product !== 16'h03FC || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_fp: got %h done=%b expected 03fc done=0", product, done);
    end
    // en_i with en_pp in the same cycle: load wins, full 8 steps follow.
    multiplicand = 8'hFE;
    multiplier   = 8'h55;
    en_i  = 1'b1;
    en_pp = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL load_wins_valid: got %b expected 0", valid_out);
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out) break;
      n++;
    end
    en_pp = 1'b0;
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL load_wins_pp_count: got %0d expected 8", n);
    end
    en_fp = 1'b1;
    @(negedge clk);
    en_fp = 1'b0;
    checks++;
    if (product !== 16'hFF56) begin
      failures++;
      $display("FAIL load_wins_product: got %h expected ff56", product);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int pp, lat, dn, bad;
    logic [2*WIDTH-1:0] prod, exp;
    @(negedge clk);
    multiplicand = 8'h07;
    multiplier   = 8'h03;
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_i  = 1'b0;
      en_pp = 1'b1;
    end
    @(negedge clk);
    en_pp = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (product !== 16'h0000 || done !== 1'b0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got product=%h done=%b valid_out=%b expected 0000 0 0",
               product, done, valid_out);
    end
    @(negedge clk);
    reset = 1'b1;
    // Abandoned operation: strobes now find the datapath idle.
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      en_pp = 1'b1;
      en_fp = 1'b1;
      @(negedge clk);
      if (done !== 1'b0 || valid_out !== 1'b0) bad++;
    end
    en_pp = 1'b0;
    en_fp = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad);
    end
    exp_q.push_back(16'h0051);
    run_op(8'h09, 8'h09, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp || dn !== 1) begin
      failures++;
      $display("FAIL after_reset_9x9: got %h done=%0d expected %h done=1", prod, dn, exp);
    end
  endtask

  task automatic test_early_term();
    int pp, lat, dn;
    logic [2*WIDTH-1:0] prod, exp;
    exp_q.push_back(16'h0001);
    run_op(8'h01, 8'h01, pp, lat, dn, prod);
    exp = exp_q.pop_front();
    checks++;
    if (prod !== exp) begin
      failures++;
      $display("FAIL early_1x1_product: got %h expected %h", prod, exp);
    end
    checks++;
    if (pp !== PP_1X1) begin
      failures++;
      $display("FAIL early_1x1_pp_count: got %0d expected %0d", pp, PP_1X1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_edge_operands();
    test_stray_enables();
    test_async_reset();
    test_early_term();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
Radix-2 Booth signed-multiplier datapath. It is the responder to the existing Booth controller FSM.
- Consumes the controller's en_i / en_pp / en_fp enables.
- Drives valid_out back to the controller, ending the partial-product phase.
- Holds operands, the accumulator and the iteration counter, and registers the final product.

Parameters:
WIDTH, 8, operand width in bits (signed two's complement); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
multiplicand  input  WIDTH  signed operand M, sampled on en_i
multiplier  input  WIDTH  signed operand Q, sampled on en_i
en_i  input  1  load operands and start an operation
en_pp  input  1  perform one Booth iteration
en_fp  input  1  capture final product
valid_out  output  1  all iterations complete; combinational from registers
product  output  2*WIDTH  signed product, registered
done  output  1  one-cycle pulse when product updates

Behaviour:
- Reset (reset=0, asynchronous):
  - A, Q, Q_m1, M, count, busy, product and done all cleared to 0.
  - valid_out=0.
  - Reset mid-operation abandons the operation; no done pulse follows.
- Registers:
  - A: WIDTH+1 bits, sign-extended accumulator, so -2^(WIDTH-1) cannot overflow on subtract.
  - M: WIDTH+1 bits, sign-extended.
  - Q: WIDTH bits.
  - Q_m1: 1 bit.
  - count: $clog2(WIDTH+1) bits.
  - busy: 1 bit.
- en_i, at the clock edge:
  - A=0, M=sext(multiplicand), Q=multiplier, Q_m1=0, count=WIDTH, busy=1.
  - en_i has priority over en_pp and en_fp in the same cycle.
  - en_i while busy restarts cleanly.
- en_pp, when busy and count!=0, performs one Booth step:
  - {Q[0],Q_m1}=01: A=A+M.
  - {Q[0],Q_m1}=10: A=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q_m1} by 1 (A MSB replicated), and count=count-1.
  - en_pp when count==0 or !busy is ignored.
- valid_out = busy && (count==0).
  - The controller keeps en_pp asserted while valid_out=0, then asserts en_fp.
- en_fp, when busy: product={A[WIDTH-1:0],Q}, busy=0, done=1 for exactly one cycle.
  - en_fp when !busy is ignored, and product holds.
- product holds its value until the next en_fp.
  - done is 0 in every cycle except the one following an accepted en_fp edge.
- Latency (controller-driven, base build):
  - en_i edge, then WIDTH en_pp edges, then the en_fp edge.
  - done is visible WIDTH+2 cycles after the cycle in which en_i was sampled.
- Simultaneous en_pp and en_fp: en_fp wins if valid_out=1, otherwise en_pp wins.
- Booth step arithmetic is WIDTH+1-bit wrap-around. Discarding A[WIDTH] is exact for all signed inputs, including (-2^(WIDTH-1))^2.

Optional Feature:
Macro: BOOTH_EARLY_TERM_EN.
- Defined: on an accepted en_pp, if bits Q[count-1:0] and Q_m1 are all equal (all 0 or all 1):
  - Arithmetic right shift {A,Q,Q_m1} by count in one cycle (barrel shift).
  - Set count=0, so valid_out rises after that edge.
  - Otherwise a normal step is performed.
  - Product values are identical to the base build; only iteration count drops.
- Undefined: exactly WIDTH en_pp steps always; no barrel shifter is synthesised.

Decomposition:
- Package booth_pkg:
  - Default WIDTH.
  - typedef booth_op_e {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB}, decoded from {Q[0],Q_m1}.
  - Function booth_decode returning booth_op_e.
- Sub-module booth_step: purely combinational, taking A, Q, Q_m1 and M and returning the next {A,Q,Q_m1} for one iteration.
  - booth_datapath instantiates it once and keeps all registers, counter and early-term logic.

Test Plan:
All scenarios use WIDTH=8 and drive the existing controller alongside the datapath, except scenario 4, which drives the enables directly.
1. 7 x 3 via controller (valid_in pulse) -> valid_out after 8 en_pp cycles; product=16'h0015; done pulses once; 10 cycles valid_in to done.
2. -5 x 6, then -128 x -128 back-to-back -> product=16'hFFE2, then 16'h4000 (A[8] must not corrupt the result).
3. 0 x -1 and 127 x -128 -> 16'h0000 and 16'hC080; done=1 for exactly one cycle each.
4. Stray en_pp after count==0, en_fp while idle, and en_i+en_pp in the same cycle:
   - Stray en_pp -> no state change.
   - en_fp while idle -> product unchanged, no done.
   - en_i+en_pp together -> load wins, count=8.
5. Assert reset after 4 en_pp cycles -> all outputs 0 immediately (asynchronous); the next operation 9 x 9 gives 16'h0051.
6. BOOTH_EARLY_TERM_EN defined, 1 x 1 -> valid_out after 3 en_pp cycles, product=16'h0001. Macro undefined, same stimulus -> 8 en_pp cycles, same product.
